// File: rtl/qs_beforedelete_nios2_qsys_0_ocimem_arbiter.sv
// OCI debug RAM arbiter: round-robin between JTAG command strobes and the
// CPU debug-slave port, with the JTAG-side MonAReg/MonDReg/monitor_ready.
module qs_beforedelete_nios2_qsys_0_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_grant;
    logic        jpend;
    logic        j_we;
    logic [31:0] j_wdata;
    logic        skip_inc;

    logic cpu_pend, j_req, grant_cpu, grant_j;
    logic j_busy, j_done, op_we;
    logic b_accept, b_drop;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    assign cpu_pend  = cpu_read | cpu_write;
    // A same-cycle address load cancels a pending request before it can win.
    assign j_req     = jpend & ~take_action_ocimem_a;
    assign grant_cpu = (state == IDLE) & cpu_pend & (~j_req | ~last_grant);
    assign grant_j   = (state == IDLE) & j_req & ~grant_cpu;

    assign op_we    = owner ? cpu_write : j_we;
    assign j_busy   = (state != IDLE) & ~owner;
    assign j_done   = ~owner & (((state == ISSUE) & j_we) | (state == CAPTURE));

    assign b_accept = take_action_ocimem_b & ~take_action_ocimem_a
                    & ~jpend & ~j_busy;
    assign b_drop   = take_action_ocimem_b & ~b_accept;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        unique case (state)
            IDLE: begin
                if (grant_cpu) begin
                    state_nxt = ISSUE;
                    owner_nxt = 1'b1;
                end else if (grant_j) begin
                    state_nxt = ISSUE;
                    owner_nxt = 1'b0;
                end
            end
            ISSUE:   state_nxt = op_we ? IDLE : CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_re    = (state == ISSUE) & ~op_we;
    assign ram_we    = (state == ISSUE) & op_we;
    assign ram_addr  = owner ? cpu_address : MonAReg;
    assign ram_wdata = owner ? cpu_writedata : j_wdata;

    assign cpu_waitrequest = ~(owner & (((state == ISSUE) & cpu_write)
                                      | (state == CAPTURE)));
    assign cpu_readdata    = (owner & (state == CAPTURE)) ? ram_rdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (grant_cpu | grant_j)
                last_grant <= grant_cpu;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jpend    <= 1'b0;
            j_we     <= 1'b0;
            j_wdata  <= '0;
            skip_inc <= 1'b0;
        end else begin
            if (take_action_ocimem_a)
                jpend <= 1'b0;
            else if (b_accept)
                jpend <= 1'b1;
            else if (grant_j)
                jpend <= 1'b0;
            if (b_accept) begin
                j_we    <= jdo[35];
                j_wdata <= jdo[34:3];
            end
            // A reload during an in-flight access must not be bumped on completion.
            if (grant_j)
                skip_inc <= 1'b0;
            else if (take_action_ocimem_a & j_busy)
                skip_inc <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            jtag_overrun  <= 1'b0;
        end else begin
            if (take_action_ocimem_a)
                MonAReg <= jdo[ADDR_W+1:2];
            else if (j_done & ~skip_inc)
                MonAReg <= MonAReg + ADDR_W'(1);
            if (j_done)
                MonDReg <= (state == CAPTURE) ? ram_rdata : j_wdata;
            if (j_done)
                monitor_ready <= 1'b1;
            else if (b_accept)
                monitor_ready <= 1'b0;
            if (b_drop)
                jtag_overrun <= 1'b1;
            else if (take_action_ocimem_a)
                jtag_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qs_beforedelete_nios2_qsys_0_ocimem_arbiter.sv
// Scoreboard bench for the OCI RAM arbiter with a behavioural 1-cycle RAM.
module tb_qs_beforedelete_nios2_qsys_0_ocimem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        take_a, take_b;
    logic [37:0] jdo;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_re, ram_we;
    logic [31:0] ram_rdata;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_overrun;

    logic        load;
    logic [31:0] mem [256];

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } ram_exp_t;

    ram_exp_t    exp_ram[$];
    logic [31:0] exp_cpu[$];

    int errors = 0;
    int checks = 0;

    qs_beforedelete_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .jdo                  (jdo),
        .cpu_read             (cpu_read),
        .cpu_write            (cpu_write),
        .cpu_address          (cpu_address),
        .cpu_writedata        (cpu_writedata),
        .cpu_waitrequest      (cpu_waitrequest),
        .cpu_readdata         (cpu_readdata),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_re               (ram_re),
        .ram_we               (ram_we),
        .ram_rdata            (ram_rdata),
        .MonAReg              (MonAReg),
        .MonDReg              (MonDReg),
        .monitor_ready        (monitor_ready),
        .jtag_overrun         (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 32'hC0FFEE00 | i;
            mem[8'h05] <= 32'h12345678;
            mem[8'h11] <= 32'hA5A51111;
        end else begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            if (ram_re)
                ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RAM strobe and every CPU read completion.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_re || ram_we) begin
                if (exp_ram.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ram_unexpected: got addr %h we %b expected none",
                             ram_addr, ram_we);
                end else begin
                    ram_exp_t e;
                    e = exp_ram.pop_front();
                    check("ram_we", {31'b0, ram_we}, {31'b0, e.we});
                    check("ram_addr", {24'b0, ram_addr}, {24'b0, e.addr});
                    if (e.we)
                        check("ram_wdata", ram_wdata, e.data);
                end
            end
            if (!cpu_waitrequest && cpu_read && !cpu_write) begin
                if (exp_cpu.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_unexpected: got %h expected none",
                             cpu_readdata);
                end else begin
                    check("cpu_readdata", cpu_readdata, exp_cpu.pop_front());
                end
            end
        end
    end

    function automatic ram_exp_t mk(input logic we, input logic [7:0] a,
                                    input logic [31:0] d);
        ram_exp_t e;
        e.we   = we;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic jtag_a(input logic [7:0] a);
        @(posedge clk);
        #1;
        jdo    = {28'b0, a, 2'b0};
        take_a = 1'b1;
        @(posedge clk);
        #1;
        take_a = 1'b0;
    endtask

    task automatic jtag_b(input logic we, input logic [31:0] d);
        @(posedge clk);
        #1;
        jdo    = {2'b0, we, d, 3'b0};
        take_b = 1'b1;
        @(posedge clk);
        #1;
        take_b = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!monitor_ready && n < 30);
        check(name, {31'b0, monitor_ready}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_waitreq"}, {31'b0, cpu_waitrequest}, 32'd1);
        check({tag, "_ram_re"}, {31'b0, ram_re}, 32'd0);
        check({tag, "_ram_we"}, {31'b0, ram_we}, 32'd0);
        check({tag, "_ready"}, {31'b0, monitor_ready}, 32'd0);
        check({tag, "_overrun"}, {31'b0, jtag_overrun}, 32'd0);
        check({tag, "_monareg"}, {24'b0, MonAReg}, 32'd0);
        check({tag, "_mondreg"}, MonDReg, 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        load          = 1'b1;
        take_a        = 1'b0;
        take_b        = 1'b0;
        jdo           = '0;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = 8'h05;
        cpu_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        load    = 1'b0;

        // JTAG write then read through the auto-incrementing address
        jtag_a(8'h10);
        @(negedge clk);
        check("a_load", {24'b0, MonAReg}, 32'h10);
        exp_ram.push_back(mk(1'b1, 8'h10, 32'hDEADBEEF));
        jtag_b(1'b1, 32'hDEADBEEF);
        wait_ready("jw_ready");
        check("jw_monareg", {24'b0, MonAReg}, 32'h11);
        check("jw_mondreg", MonDReg, 32'hDEADBEEF);
        exp_ram.push_back(mk(1'b0, 8'h11, 32'h0));
        jtag_b(1'b0, 32'h0);
        wait_ready("jr_ready");
        check("jr_monareg", {24'b0, MonAReg}, 32'h12);
        check("jr_mondreg", MonDReg, 32'hA5A51111);

        // Uncontended CPU read: waitrequest low only in cycle 2
        exp_ram.push_back(mk(1'b0, 8'h05, 32'h0));
        exp_cpu.push_back(32'h12345678);
        @(posedge clk);
        #1;
        cpu_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cpu_wait_cyc", {31'b0, cpu_waitrequest},
                  (i == 2) ? 32'd0 : 32'd1);
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        @(negedge clk);
        check("cpu_wait_idle", {31'b0, cpu_waitrequest}, 32'd1);

        // Contention: grants alternate CPU / JTAG
        exp_ram.push_back(mk(1'b0, 8'h05, 32'h0));
        exp_ram.push_back(mk(1'b0, 8'h12, 32'h0));
        exp_ram.push_back(mk(1'b0, 8'h05, 32'h0));
        exp_ram.push_back(mk(1'b0, 8'h13, 32'h0));
        exp_ram.push_back(mk(1'b0, 8'h05, 32'h0));
        exp_ram.push_back(mk(1'b0, 8'h14, 32'h0));
        repeat (3) exp_cpu.push_back(32'h12345678);
        fork
            begin
                int done, n;
                done = 0;
                n    = 0;
                @(posedge clk);
                #1;
                cpu_read = 1'b1;
                while (done < 3 && n < 100) begin
                    @(negedge clk);
                    n++;
                    if (!cpu_waitrequest)
                        done++;
                end
                check("cont_cpu_done", done, 3);
                @(posedge clk);
                #1;
                cpu_read = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    jtag_b(1'b0, 32'h0);
                    wait_ready("cont_ready");
                    check("cont_mondreg", MonDReg, 32'hC0FFEE12 + k);
                end
            end
        join
        check("cont_monareg", {24'b0, MonAReg}, 32'h15);

        // Address wrap
        jtag_a(8'hFF);
        exp_ram.push_back(mk(1'b1, 8'hFF, 32'h0BADF00D));
        jtag_b(1'b1, 32'h0BADF00D);
        wait_ready("wrap_ready");
        check("wrap_monareg", {24'b0, MonAReg}, 32'h00);
        check("wrap_mondreg", MonDReg, 32'h0BADF00D);

        // Overrun: two consecutive strobes, one access
        jtag_a(8'h30);
        exp_ram.push_back(mk(1'b0, 8'h30, 32'h0));
        @(posedge clk);
        #1;
        jdo    = '0;
        take_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        take_b = 1'b0;
        wait_ready("ovr_ready");
        repeat (5) @(negedge clk);
        check("ovr_flag", {31'b0, jtag_overrun}, 32'd1);
        check("ovr_monareg", {24'b0, MonAReg}, 32'h31);
        check("ovr_mondreg", MonDReg, 32'hC0FFEE30);
        jtag_a(8'h40);
        @(negedge clk);
        check("ovr_clear", {31'b0, jtag_overrun}, 32'd0);
        check("ovr_monareg2", {24'b0, MonAReg}, 32'h40);

        // Address load during CAPTURE: no increment, data still captured
        exp_ram.push_back(mk(1'b0, 8'h40, 32'h0));
        jtag_b(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        jdo    = {28'b0, 8'h50, 2'b0};
        take_a = 1'b1;
        @(posedge clk);
        #1;
        take_a = 1'b0;
        @(negedge clk);
        check("midcap_monareg", {24'b0, MonAReg}, 32'h50);
        check("midcap_mondreg", MonDReg, 32'hC0FFEE40);
        check("midcap_ready", {31'b0, monitor_ready}, 32'd1);
        exp_ram.push_back(mk(1'b1, 8'h50, 32'h5A5A0050));
        jtag_b(1'b1, 32'h5A5A0050);
        wait_ready("post_ready");
        check("post_monareg", {24'b0, MonAReg}, 32'h51);

        // Reset during ISSUE aborts the write asynchronously
        jtag_a(8'h60);
        jtag_b(1'b1, 32'h11112222);
        @(posedge clk);
        #1;
        check("rst_pre_we", {31'b0, ram_we}, 32'd1);
        check("rst_pre_addr", {24'b0, ram_addr}, 32'h60);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_idle_we", {31'b0, ram_we}, 32'd0);
        check("midrst_monareg", {24'b0, MonAReg}, 32'h00);

        check("exp_ram_left", exp_ram.size(), 0);
        check("exp_cpu_left", exp_cpu.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
